// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - state encoding, parity codes and frame-length helper for uart_tx_frame
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int frame_bits(input int data_bits, input int par, input int stop_bits);
    return 1 + data_bits + ((par != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-time divider; tick pulses on wrap, clear restarts the count
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A tick coinciding with accept would belong to the old count, so suppress it.
  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame serialiser (start, data LSB first, parity, stop).
// Parity bit and PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ACTIVE = (PARITY != PAR_NONE);
`else
  localparam bit PAR_ACTIVE = 1'b0;
`endif

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 par_bit;
  logic                 accept;
  logic                 tick;

  assign in_ready   = (state_q == IDLE) && !reset;
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;
  assign frame_done = done_q;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .tick  (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk) begin
    if (reset)       par_q <= 1'b0;
    else if (accept) par_q <= (PARITY == PAR_EVEN) ? ^in_data : ~^in_data;
  end
  assign par_bit = par_q;
`else
  assign par_bit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      IDLE: if (accept) begin
        state_d   = START;
        shift_d   = in_data;
        bit_cnt_d = '0;
      end
      START: if (tick) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (tick) begin
        if (bit_cnt_q == DATA_LAST) begin
          state_d   = PAR_ACTIVE ? uart_pkg::PARITY : STOP;
          bit_cnt_d = '0;
        end else begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      uart_pkg::PARITY: if (tick) begin
        state_d   = STOP;
        bit_cnt_d = '0;
      end
      STOP: if (tick) begin
        if (bit_cnt_q == STOP_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level is registered from the next state so it changes on the bit edge itself.
    case (state_d)
      START:            tx_d = 1'b0;
      DATA:             tx_d = shift_d[0];
      uart_pkg::PARITY: tx_d = par_bit;
      default:          tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - table and scoreboard bench for three uart_tx_frame configurations
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0] valid_w, rdy_w, tx_w, busy_w, done_w;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_frame dut0 (
    .clk(clk), .reset(reset), .in_data(d0), .in_valid(valid_w[0]), .in_ready(rdy_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0])
  );

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(d1), .in_valid(valid_w[1]), .in_ready(rdy_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1])
  );

  uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(2), .STOP_BITS(2), .PARITY(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(d2), .in_valid(valid_w[2]), .in_ready(rdy_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2])
  );

  function automatic int cfg_db(input int i);   return (i == 2) ? 7 : 8; endfunction
  function automatic int cfg_cpb(input int i);  return (i == 1) ? 4 : ((i == 2) ? 2 : 1); endfunction
  function automatic int cfg_stop(input int i); return (i == 2) ? 2 : 1; endfunction

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
    logic rdy;
  } exp_t;

  typedef struct {
    int         idx;
    logic [8:0] word;
    int         exp_f;
    logic       exp_par;
  } vec_t;

  exp_t sb[$];
  int   mon_idx = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d, cycle %0d): got %0h, expected %0h", name, mon_idx, cyc, act, exp);
    end
  endtask

  task automatic set_data(input int idx, input logic [8:0] w);
    case (idx)
      0:       d0 = w[7:0];
      1:       d1 = w[7:0];
      default: d2 = w[6:0];
    endcase
  endtask

  // Expected per-cycle outputs for one frame, starting the cycle after the accept edge.
  task automatic push_frame(input int idx, input logic [8:0] word, input int exp_f, input logic exp_par);
    logic fb[$];
    int   has_par;
    has_par = exp_f - 1 - cfg_db(idx) - cfg_stop(idx);
    fb.push_back(1'b0);
    for (int i = 0; i < cfg_db(idx); i++) fb.push_back(word[i]);
    if (has_par == 1) fb.push_back(exp_par);
    for (int i = 0; i < cfg_stop(idx); i++) fb.push_back(1'b1);
    chk("frame_len_model", fb.size(), exp_f);
    foreach (fb[k])
      for (int c = 0; c < cfg_cpb(idx); c++) sb.push_back('{tx: fb[k], busy: 1'b1, done: 1'b0, rdy: 1'b0});
    sb.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1, rdy: 1'b1});
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("tx", tx_w[mon_idx], e.tx);
        chk("busy", busy_w[mon_idx], e.busy);
        chk("frame_done", done_w[mon_idx], e.done);
        chk("in_ready", rdy_w[mon_idx], e.rdy);
      end
    end
  end

  task automatic drain(input int idx, input bit scramble);
    int t;
    t = 0;
    while (sb.size() > 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
      if (scramble) set_data(idx, 9'($urandom));
    end
    if (sb.size() > 0) begin
      chk("scoreboard_drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic send(input int idx, input logic [8:0] word, input int exp_f, input logic exp_par,
                      input bit scramble);
    @(negedge clk);
    mon_idx = idx;
    chk("ready_before_accept", rdy_w[idx], 1);
    set_data(idx, word);
    valid_w[idx] = 1'b1;
    @(posedge clk);
    #1;
    valid_w[idx] = 1'b0;
    push_frame(idx, word, exp_f, exp_par);
    drain(idx, scramble);
  endtask

  vec_t vecs[8];

  initial begin
    int  t;
    int  t0;
    bit  seen_done;

    vecs[0] = '{0, 9'h055, 10, 1'b0};
    vecs[1] = '{0, 9'h0A3, 10, 1'b0};
    vecs[2] = '{0, 9'h0FF, 10, 1'b0};
    vecs[3] = '{1, 9'h0A5, PAR_EN ? 11 : 10, 1'b1};
    vecs[4] = '{1, 9'h001, PAR_EN ? 11 : 10, 1'b0};
    vecs[5] = '{2, 9'h07F, PAR_EN ? 11 : 10, 1'b1};
    vecs[6] = '{2, 9'h003, PAR_EN ? 11 : 10, 1'b0};
    vecs[7] = '{2, 9'h040, PAR_EN ? 11 : 10, 1'b1};

    reset   = 1'b1;
    valid_w = '0;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mon_idx = i;
      chk("reset_tx", tx_w[i], 1);
      chk("reset_busy", busy_w[i], 0);
      chk("reset_done", done_w[i], 0);
      chk("reset_ready", rdy_w[i], 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", rdy_w[0], 1);

    for (int i = 0; i < 8; i++)
      send(vecs[i].idx, vecs[i].word, vecs[i].exp_f, vecs[i].exp_par, (i % 2) == 1);

    // Back-to-back with in_valid held: 0x00 then 0xFF.
    @(negedge clk);
    mon_idx = 0;
    set_data(0, 9'h000);
    valid_w[0] = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    push_frame(0, 9'h000, 10, 1'b0);
    set_data(0, 9'h0FF);
    t = 0;
    while (!rdy_w[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_ready_seen", rdy_w[0], 1);
    @(posedge clk);
    #1;
    chk("b2b_spacing", cyc - t0, 11);
    push_frame(0, 9'h0FF, 10, 1'b0);
    valid_w[0] = 1'b0;
    drain(0, 1'b0);

    // Reset pulsed during data bit 3 (word bit 3 is 0).
    @(negedge clk);
    mon_idx = 0;
    set_data(0, 9'h0F7);
    valid_w[0] = 1'b1;
    @(posedge clk);
    #1;
    valid_w[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_bit3_tx", tx_w[0], 0);
    chk("mid_bit3_busy", busy_w[0], 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx_w[0], 1);
    chk("abort_busy", busy_w[0], 0);
    seen_done = 1'b0;
    repeat (12) begin
      seen_done |= done_w[0];
      @(negedge clk);
    end
    chk("abort_no_done", seen_done, 0);
    send(0, 9'h0C3, 10, 1'b0, 1'b1);

    // Reset and in_valid together: nothing accepted.
    @(negedge clk);
    reset = 1'b1;
    valid_w[0] = 1'b1;
    set_data(0, 9'h012);
    #1;
    chk("reset_valid_ready", rdy_w[0], 0);
    @(negedge clk);
    chk("reset_valid_busy", busy_w[0], 0);
    chk("reset_valid_tx", tx_w[0], 1);
    valid_w[0] = 1'b0;
    reset = 1'b0;
    send(1, 9'h03C, PAR_EN ? 11 : 10, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, the successor to `tx_module`. It serialises one parallel word per frame onto `tx`, LSB first, in the order start bit, data bits, optional parity, stop bit(s). Input uses a valid/ready handshake, and bit time is set by a programmable clock divider. Its output feeds a line driver or, in benches, a `shift_reg_sipo` of width equal to the frame length.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.
- `CLKS_PER_BIT`, default 1: clock cycles per bit, must be ≥1.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even. Only honoured when `UART_TX_PARITY_EN` is defined.

Ports:
- `clk`  in  1: the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `in_data`  in  DATA_BITS: word to send. Sampled on accept only.
- `in_valid`  in  1: word available.
- `in_ready`  out  1: block can accept a word.
- `tx`  out  1: serial line. Idle level is 1.
- `busy`  out  1: a frame is in progress.
- `frame_done`  out  1: one-cycle pulse at the end of the last stop bit.

## Operation
- **Accept.** A word is accepted on a rising `clk` when `in_valid && in_ready`. `in_data` is latched into a shift register, and the bit counter and divider clear.
- **State machine.** States are IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when parity is disabled or `PARITY`=0.
  - Each state except IDLE holds for exactly `CLKS_PER_BIT` cycles per bit.
  - DATA holds for `DATA_BITS` bits and STOP for `STOP_BITS` bits.
- **`tx` per state.** IDLE=1, START=0, DATA=shift[0] (then shift right), PARITY=computed bit, STOP=1.
- **Parity.**
  - Even: `^data`.
  - Odd: `~^data`.
  - Computed once from the latched word at accept.
- **`in_ready`.** Equals (state==IDLE) && !reset. It is never high in the same cycle as `busy`.
- **`in_valid` while busy.** Ignored. No buffering.
- **Held input.** `in_data` may change after accept without affecting the frame.
- **Divider.** Counter width is `$clog2(CLKS_PER_BIT)`, with a minimum of 1. It counts 0..CLKS_PER_BIT-1 and wraps. The bit advances on the wrap.

## Timing
- **Reset values** (at the first edge with `reset`=1): state IDLE, `tx`=1, `busy`=0, `frame_done`=0, `in_ready`=0 while reset is held.
- **Reset mid-frame.** The frame is abandoned at the next edge and `tx` returns to 1. No `frame_done` pulse is generated.
- **Latency.** The accept edge is cycle 0. `tx` goes 0 (start bit) from cycle 0+ and is registered, so it is visible right after the accept edge.
- **Frame length.** F = 1 + DATA_BITS + P + STOP_BITS bits, where P = 1 if parity is active, else 0. `busy` is high for F×CLKS_PER_BIT cycles.
- **`frame_done`.** High for exactly the cycle in which state returns to IDLE. `in_ready` rises in that same cycle.
- **Back-to-back throughput.** The minimum accept-to-accept spacing is F×CLKS_PER_BIT + 1 cycles. There is one mandatory IDLE cycle of `tx`=1.
- **Reset and `in_valid` together.** Reset wins and nothing is accepted.

## Configuration
- `UART_TX_PARITY_EN` defined: the parity logic and the PARITY state are compiled in, and `PARITY` selects none, odd or even.
- Not defined: there is no parity hardware, the PARITY state is absent, and `PARITY` is ignored and treated as 0. The frame is always 1 + DATA_BITS + STOP_BITS bits.

## Structure
- **Package `uart_pkg`.**
  - State enum `tx_state_t` with values IDLE, START, DATA, PARITY, STOP.
  - Parity constants `PAR_NONE`=0, `PAR_ODD`=1, `PAR_EVEN`=2.
  - Function `frame_bits(data_bits, par, stop_bits)`.
- **Sub-module `baud_tick_gen`.** Parameter CLKS_PER_BIT; ports `clk`, `reset`, `clear`, `tick`. `tick` pulses on divider wrap, and `clear` restarts the count on accept. The FSM and shifter stay in the top module.

## Test plan
- **Default, 0x55.** Defaults, one word 8'b01010101, sampled by an 11-bit `shift_reg_sipo` for the idle bit plus frame. Expected `tx` sequence: 0,1,0,1,0,1,0,1,0,1 (start, LSBs first, stop). `frame_done` is high exactly 10 cycles after accept.
- **Odd parity, 0xA5.** `UART_TX_PARITY_EN`, `PARITY`=1, `CLKS_PER_BIT`=4, 0xA5 (four ones). Parity bit = 1. Each bit is held 4 cycles and `busy` is high for 44 cycles.
- **Even parity, two stop bits.** `PARITY`=2, `STOP_BITS`=2, `DATA_BITS`=7, word 7'h7F. Parity = 1. Stop is high for 2 bit times and F=11.
- **Back-to-back.** `in_valid` held high with words 0x00 then 0xFF. The second accept comes exactly F×CLKS_PER_BIT+1 cycles after the first, with one idle `tx`=1 cycle between frames. `in_ready` is never high while `busy`.
- **Reset mid-frame.** `reset` pulsed during DATA bit 3. Next cycle `tx`=1, `busy`=0, no `frame_done` pulse. A following word is sent intact.
- **Input changes after accept.** Toggle `in_data` every cycle after accept. The serialised bits match the value latched at accept.
